// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe
//   Multi-cycle floating-point adder/subtractor. It handles one operation at
//   a time and supports configurable exponent and mantissa widths. It rounds
//   to nearest-even using guard, round and sticky bits, and it overflows to
//   infinity. Subnormal inputs are flushed to zero.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands/op valid
//   in_ready   block idle and able to accept
//   op         0 = a+b, 1 = a-b
//   a, b       operands {sign, exp, man}
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   result     {sign, exp, man}
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for in_valid; swap, classify and fast path at accept
// ALIGN | shift smaller mantissa right one bit per cycle (or clamp to sticky)
// ADD   | add or subtract the aligned mantissas
// NORM  | carry right shift, or left shift one bit per cycle
// ROUND | round to nearest even, detect overflow
// DONE  | result presented until out_ready
module fpu_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result
);

  localparam int W  = 1 + EXP_W + MAN_W;
  // working mantissa {hidden, man, G, R, S}
  localparam int MW = MAN_W + 4;
  // sum adds a carry bit on top of the working mantissa
  localparam int SW = MAN_W + 5;

  localparam logic [EXP_W-1:0] EXP_ONES   = '1;
  localparam logic [EXP_W:0]   EXP_ONES_X = {1'b0, EXP_ONES};
  localparam logic [EXP_W:0]   EXP_ONE    = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] DIFF_ONE   = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0]    MB_STICKY  = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [MAN_W-1:0] NAN_MAN    = {1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic             sign_a, sign_a_nxt;
  logic             sign_b, sign_b_nxt;
  logic [EXP_W:0]   exp_r, exp_nxt;
  logic [EXP_W-1:0] diff, diff_nxt;
  logic [MW-1:0]    ma, ma_nxt;
  logic [MW-1:0]    mb, mb_nxt;
  logic [SW-1:0]    sum, sum_nxt;
  logic [W-1:0]     result_nxt;

  // operand decode at accept
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             zero_a, zero_b, inf_a, inf_b, swap;
  logic             big_s, sml_s;
  logic [EXP_W-1:0] big_e, sml_e;
  logic [MAN_W-1:0] big_m, sml_m;
  logic             zero_sml, fast_hit;
  logic [W-1:0]     fast_res;

  assign sa     = a[W-1];
  assign sb     = b[W-1] ^ op;
  assign ea     = a[W-2:MAN_W];
  assign eb     = b[W-2:MAN_W];
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign inf_a  = (ea == EXP_ONES);
  assign inf_b  = (eb == EXP_ONES);
  // flushed mantissas so subnormals compare and pass through as zero
  assign fa     = zero_a ? '0 : a[MAN_W-1:0];
  assign fb     = zero_b ? '0 : b[MAN_W-1:0];
  assign swap   = ({eb, fb} > {ea, fa});

  assign big_s    = swap ? sb : sa;
  assign big_e    = swap ? eb : ea;
  assign big_m    = swap ? fb : fa;
  assign sml_s    = swap ? sa : sb;
  assign sml_e    = swap ? ea : eb;
  assign sml_m    = swap ? fa : fb;
  // after the swap a zero larger operand implies a zero smaller one, so the
  // "smaller is zero" test alone covers every zero case
  assign zero_sml = swap ? zero_a : zero_b;
  assign fast_hit = inf_a | inf_b | zero_sml;

  always_comb begin
    fast_res = {big_s, big_e, big_m};
    if (inf_a && inf_b && (sa != sb)) begin
      fast_res = {1'b0, EXP_ONES, NAN_MAN};
    end else if (inf_a) begin
      fast_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      fast_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  // datapath helpers
  logic [SW-1:0]    add_sum;
  logic             rnd_up;
  logic [MAN_W:0]   man_rnd;
  logic [EXP_W:0]   exp_rnd;

  assign add_sum = (sign_a == sign_b) ? ({1'b0, ma} + {1'b0, mb})
                                      : ({1'b0, ma} - {1'b0, mb});
  assign rnd_up  = sum[2] & (sum[1] | sum[0] | sum[3]);
  // stored mantissa field only; the hidden bit is 1 in ROUND, so a carry out
  // of this field means the significand became 10.000...
  assign man_rnd = {1'b0, sum[SW-3:3]} + {{MAN_W{1'b0}}, rnd_up};
  assign exp_rnd = exp_r + {{EXP_W{1'b0}}, man_rnd[MAN_W]};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sign_a_nxt = sign_a;
    sign_b_nxt = sign_b;
    exp_nxt    = exp_r;
    diff_nxt   = diff;
    ma_nxt     = ma;
    mb_nxt     = mb;
    sum_nxt    = sum;
    result_nxt = result;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (fast_hit) begin
            result_nxt = fast_res;
            state_nxt  = DONE;
          end else begin
            sign_a_nxt = big_s;
            sign_b_nxt = sml_s;
            exp_nxt    = {1'b0, big_e};
            diff_nxt   = big_e - sml_e;
            ma_nxt     = {1'b1, big_m, 3'b000};
            mb_nxt     = {1'b1, sml_m, 3'b000};
            state_nxt  = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (diff == '0) begin
          state_nxt = ADD;
        end else if (32'(diff) >= MW) begin
          // everything shifts out: only the sticky bit survives
          mb_nxt   = MB_STICKY;
          diff_nxt = '0;
        end else begin
          mb_nxt   = {1'b0, mb[MW-1:2], mb[1] | mb[0]};
          diff_nxt = diff - DIFF_ONE;
        end
      end
      ADD: begin
        sum_nxt = add_sum;
        if (add_sum == '0) begin
          result_nxt = '0;
          state_nxt  = DONE;
        end else if (add_sum[SW-1] || !add_sum[SW-2]) begin
          state_nxt = NORM;
        end else begin
          state_nxt = ROUND;
        end
      end
      NORM: begin
        if (sum[SW-1]) begin
          sum_nxt   = {1'b0, sum[SW-1:2], sum[1] | sum[0]};
          exp_nxt   = exp_r + EXP_ONE;
          state_nxt = ROUND;
        end else if (!sum[SW-2]) begin
          if (exp_r == EXP_ONE) begin
            result_nxt = {sign_a, {(W-1){1'b0}}};
            state_nxt  = DONE;
          end else begin
            sum_nxt = {sum[SW-2:0], 1'b0};
            exp_nxt = exp_r - EXP_ONE;
            // the bit below the hidden position becomes the hidden bit
            if (sum[SW-3]) begin
              state_nxt = ROUND;
            end
          end
        end else begin
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        if (exp_rnd >= EXP_ONES_X) begin
          result_nxt = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
          result_nxt = {sign_a, exp_rnd[EXP_W-1:0], man_rnd[MAN_W-1:0]};
        end
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      exp_r  <= '0;
      diff   <= '0;
      ma     <= '0;
      mb     <= '0;
      sum    <= '0;
      result <= '0;
    end else begin
      sign_a <= sign_a_nxt;
      sign_b <= sign_b_nxt;
      exp_r  <= exp_nxt;
      diff   <= diff_nxt;
      ma     <= ma_nxt;
      mb     <= mb_nxt;
      sum    <= sum_nxt;
      result <= result_nxt;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// tb_fpu_addsub_pipe
//   Directed bench for fpu_addsub_pipe. The bench covers the default
//   half-precision widths and one single-precision instance. Each issued
//   operation pushes its expected result and latency into a queue. A monitor
//   per instance pops the queue and compares when out_valid rises.
module tb_fpu_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic        in_valid32, in_ready32, op32, out_valid32, out_ready32;
  logic [31:0] a32, b32, result32;

  fpu_addsub_pipe dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  fpu_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .op(op32), .a(a32), .b(b32), .out_valid(out_valid32),
    .out_ready(out_ready32), .result(result32)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          c0;
    string       name;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  initial begin : mon16
    exp_t e;
    logic seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (q16.size() == 0) begin
          chk("unexpected out_valid16", {31'b0, out_valid}, 32'd0);
        end else begin
          e = q16.pop_front();
          chk({e.name, " result"}, {16'b0, result}, e.res);
          chk({e.name, " latency"}, cyc - e.c0, e.lat);
          chk({e.name, " in_ready while done"}, {31'b0, in_ready}, 32'd0);
        end
      end
      if (!out_valid) seen = 1'b0;
    end
  end

  initial begin : mon32
    exp_t e;
    logic seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid32 && !seen) begin
        seen = 1'b1;
        if (q32.size() == 0) begin
          chk("unexpected out_valid32", {31'b0, out_valid32}, 32'd0);
        end else begin
          e = q32.pop_front();
          chk({e.name, " result"}, result32, e.res);
          chk({e.name, " latency"}, cyc - e.c0, e.lat);
        end
      end
      if (!out_valid32) seen = 1'b0;
    end
  end

  // called at a negedge; returns at the negedge after the accept edge
  task automatic issue16(input logic [15:0] ta, input logic [15:0] tb_v, input logic top,
                         input logic [15:0] r, input int l, input string n);
    int k;
    k = 0;
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({n, " ready to accept"}, {31'b0, in_ready}, 32'd1);
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    q16.push_back('{res: {16'b0, r}, lat: l, c0: cyc, name: n});
    @(posedge clk);
    #1;
    // scribble inputs while busy; the block must ignore them
    in_valid = 1'b0; a = 16'hFFFF; b = 16'h1234; op = ~top;
    @(negedge clk);
    chk({n, " in_ready after accept"}, {31'b0, in_ready}, 32'd0);
  endtask

  task automatic drain16();
    int k;
    k = 0;
    while ((q16.size() != 0 || out_valid) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain16 pending", q16.size(), 32'd0);
    q16.delete();
  endtask

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_v, input logic top,
                       input logic [15:0] r, input int l, input string n);
    issue16(ta, tb_v, top, r, l, n);
    drain16();
  endtask

  task automatic run32(input logic [31:0] ta, input logic [31:0] tb_v, input logic top,
                       input logic [31:0] r, input int l, input string n);
    int k;
    k = 0;
    while (!in_ready32 && k < 300) begin
      @(negedge clk);
      k++;
    end
    a32 = ta; b32 = tb_v; op32 = top; in_valid32 = 1'b1;
    q32.push_back('{res: r, lat: l, c0: cyc, name: n});
    @(posedge clk);
    #1;
    in_valid32 = 1'b0; a32 = 32'hDEADBEEF;
    k = 0;
    while ((q32.size() != 0 || out_valid32) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain32 pending", q32.size(), 32'd0);
    q32.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; op32 = 1'b0; out_ready32 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset result", {16'b0, result}, 32'd0);
    chk("reset result32", result32, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run16(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 5,  "1+1 carry");
    run16(16'h3C00, 16'h4000, 1'b0, 16'h4200, 5,  "1+2 swap");
    run16(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 6,  "1-2 swap");
    run16(16'hC000, 16'h3C00, 1'b0, 16'hBC00, 6,  "-2+1");
    run16(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 15, "tie to even");
    run16(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 15, "round up");
    run16(16'h3FFF, 16'h1000, 1'b0, 16'h4000, 15, "round carry");
    run16(16'h3C00, 16'h0400, 1'b0, 16'h3C00, 5,  "align clamp");
    run16(16'h3C01, 16'h3C00, 1'b1, 16'h1400, 14, "norm 10 shifts");
    run16(16'h0401, 16'h0400, 1'b1, 16'h0000, 4,  "norm underflow");
    run16(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5,  "overflow inf");
    run16(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3,  "cancel");
    run16(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1,  "inf-inf nan");
    run16(16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 1,  "-inf+1");
    run16(16'h3C00, 16'h0000, 1'b0, 16'h3C00, 1,  "b zero");
    run16(16'h0000, 16'h0000, 1'b1, 16'h0000, 1,  "+0-+0");
    run16(16'h8000, 16'h8000, 1'b0, 16'h8000, 1,  "-0+-0");
    run16(16'h3C00, 16'h0001, 1'b0, 16'h3C00, 1,  "subnormal flush");

    // backpressure
    out_ready = 1'b0;
    issue16(16'h3C00, 16'h4000, 1'b0, 16'h4200, 5, "stall");
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("stall reached done", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall result", {16'b0, result}, 32'h4200);
      chk("stall out_valid", {31'b0, out_valid}, 32'd1);
      chk("stall in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    drain16();

    // reset while in ALIGN aborts with no output
    issue16(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 15, "aborted");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort result", {16'b0, result}, 32'd0);
    q16.delete();
    @(negedge clk);
    rst = 1'b0;
    run16(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 15, "after reset");

    run32(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5, "fp32 1+2");
    run32(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3, "fp32 cancel");
    run32(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1, "fp32 inf+1");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
